// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register.
//
// Captures the fetched instruction, its PC and PC+4 on every rising edge.
// The register holds its contents on a stall. On a flush, or when no valid
// fetch is present, it loads a bubble (addi x0,x0,0, PC=0, invalid).
//
// The decoded rs1/rs2/rd fields come from the registered instruction. A field
// is forced to x0 when the opcode does not use it, so the RAW hazard detector
// never stalls on an unused field.
//
// A watchdog raises a sticky StallTimeout flag after STALL_LIMIT consecutive
// stall edges.
//
// Optional feature: define IFID_PERF_CNT_EN to build the StallCnt, FlushCnt
// and BubbleCnt performance counters. When it is undefined, those three ports
// are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   InstrF, PCF, PCPlus4F   fetch-stage instruction, PC and PC+4
//   ValidF                  fetch-stage data valid
//   StallD, FlushD          hold / bubble controls (flush has priority)
//   InstrD, PCD, PCPlus4D   registered instruction, PC and PC+4
//   ValidD                  InstrD is a real instruction
//   Rs1D, Rs2D, RdD         decoded register fields, 0 when unused
//   StallTimeout            sticky watchdog flag
//   StallCnt, FlushCnt, BubbleCnt   performance counters
module if_id_pipe_reg #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            ValidF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  output logic            StallTimeout,
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt,
  output logic [31:0]     BubbleCnt
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, pc_plus4_q;
  logic            valid_q;
  logic [7:0]      wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            hold;

  // Flush has priority over stall. A simultaneous stall+flush is a flush.
  assign hold = StallD & ~FlushD;

  // Pipeline data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= Nop;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (FlushD || (!StallD && !ValidF)) begin
      instr_q    <= Nop;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!StallD) begin
      instr_q    <= InstrF;
      pc_q       <= PCF;
      pc_plus4_q <= PCPlus4F;
      valid_q    <= 1'b1;
    end
  end

  // Stall watchdog: saturating count of consecutive hold edges
  always_comb begin
    wd_d      = 8'd0;
    timeout_d = timeout_q;
    if (hold) begin
      wd_d = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;
      if (wd_d == 8'(STALL_LIMIT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;
  logic        bubble_load;

  // Only bubbles caused by an empty fetch are counted, not flushes.
  assign bubble_load = ~FlushD & ~StallD & ~ValidF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hold)        stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (FlushD)      flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (bubble_load) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`else
  assign StallCnt  = 32'd0;
  assign FlushCnt  = 32'd0;
  assign BubbleCnt = 32'd0;
`endif

  // Field decode from the registered instruction only, so no input reaches
  // an output combinationally.
  always_comb begin
    Rs1D = 5'd0;
    Rs2D = 5'd0;
    RdD  = 5'd0;
    if (valid_q) begin
      case (instr_q[6:0])
        7'b1100111, 7'b0000011, 7'b0010011: begin  // jalr, load, op-imm
          Rs1D = instr_q[19:15];
          RdD  = instr_q[11:7];
        end
        7'b1100011, 7'b0100011: begin              // branch, store
          Rs1D = instr_q[19:15];
          Rs2D = instr_q[24:20];
        end
        7'b0110011: begin                          // op
          Rs1D = instr_q[19:15];
          Rs2D = instr_q[24:20];
          RdD  = instr_q[11:7];
        end
        7'b0110111, 7'b0010111, 7'b1101111: begin  // lui, auipc, jal
          RdD = instr_q[11:7];
        end
        default: ;
      endcase
    end
  end

  assign InstrD       = instr_q;
  assign PCD          = pc_q;
  assign PCPlus4D     = pc_plus4_q;
  assign ValidD       = valid_q;
  assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

`ifdef IFID_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF, StallD, FlushD;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        StallTimeout;
  logic [31:0] StallCnt, FlushCnt, BubbleCnt;

  int checks = 0;
  int errors = 0;

  if_id_pipe_reg #(
    .XLEN       (32),
    .STALL_LIMIT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .ValidF      (ValidF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdD         (RdD),
    .StallTimeout(StallTimeout),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt),
    .BubbleCnt   (BubbleCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    InstrF   = instr;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    ValidF   = 1'b1;
  endtask

  task automatic check_fields(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd);
    check({tag, ".rs1"}, 32'(Rs1D), 32'(rs1));
    check({tag, ".rs2"}, 32'(Rs2D), 32'(rs2));
    check({tag, ".rd"},  32'(RdD),  32'(rd));
  endtask

  initial begin
    rst_n  = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    fetch(32'h0020_80B3, 32'h100);  // add x1,x1,x2
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst.instr",   InstrD, 32'h0000_0013);
    check("rst.pc",      PCD, 32'h0);
    check("rst.pc4",     PCPlus4D, 32'h0);
    check("rst.valid",   32'(ValidD), 32'h0);
    check_fields("rst", 5'd0, 5'd0, 5'd0);
    check("rst.timeout", 32'(StallTimeout), 32'h0);
    check("rst.stallcnt",  StallCnt, 32'h0);
    check("rst.flushcnt",  FlushCnt, 32'h0);
    check("rst.bubblecnt", BubbleCnt, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // add x1,x1,x2
    step();
    check("add.instr", InstrD, 32'h0020_80B3);
    check("add.pc",    PCD, 32'h100);
    check("add.pc4",   PCPlus4D, 32'h104);
    check("add.valid", 32'(ValidD), 32'h1);
    check_fields("add", 5'd1, 5'd2, 5'd1);

    // lui x5
    fetch(32'h0000_12B7, 32'h104);
    step();
    check("lui.instr", InstrD, 32'h0000_12B7);
    check_fields("lui", 5'd0, 5'd0, 5'd5);

    // sw x3,0(x4)
    fetch(32'h0032_2023, 32'h108);
    step();
    check("sw.pc", PCD, 32'h108);
    check_fields("sw", 5'd4, 5'd3, 5'd0);

    // Three stall edges while fetch keeps changing
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0041_8233 + 32'(i), 32'h10C + 32'(4 * i));
      step();
    end
    check("stall.instr", InstrD, 32'h0032_2023);
    check("stall.pc",    PCD, 32'h108);
    check("stall.pc4",   PCPlus4D, 32'h10C);
    check("stall.valid", 32'(ValidD), 32'h1);
    check("stall.cnt",   StallCnt, Perf ? 32'd3 : 32'd0);
    check("stall.timeout", 32'(StallTimeout), 32'h0);

    // Simultaneous stall and flush: bubble, counted as flush only
    FlushD = 1'b1;
    step();
    FlushD = 1'b0;
    check("flush.instr", InstrD, 32'h0000_0013);
    check("flush.pc",    PCD, 32'h0);
    check("flush.valid", 32'(ValidD), 32'h0);
    check_fields("flush", 5'd0, 5'd0, 5'd0);
    check("flush.fcnt",  FlushCnt, Perf ? 32'd1 : 32'd0);
    check("flush.scnt",  StallCnt, Perf ? 32'd3 : 32'd0);

    // Watchdog restarted by the flush: trips on the 4th consecutive stall
    for (int i = 0; i < 3; i++) step();
    check("wd.before", 32'(StallTimeout), 32'h0);
    step();
    check("wd.trip", 32'(StallTimeout), 32'h1);
    check("wd.scnt", StallCnt, Perf ? 32'd7 : 32'd0);

    // Flag stays set once the stall is released
    StallD = 1'b0;
    fetch(32'h0000_0067, 32'h200);  // jalr x0,0(x0)
    step();
    check("wd.sticky",  32'(StallTimeout), 32'h1);
    check("jalr.instr", InstrD, 32'h0000_0067);
    check("jalr.pc4",   PCPlus4D, 32'h204);
    check_fields("jalr", 5'd0, 5'd0, 5'd0);

    // beq x6,x7 to check branch decode: rs1=6 rs2=7, rd masked
    fetch(32'h0073_0463, 32'h204);
    step();
    check_fields("beq", 5'd6, 5'd7, 5'd0);

    // Two empty fetch cycles
    ValidF = 1'b0;
    step();
    step();
    check("bub.instr", InstrD, 32'h0000_0013);
    check("bub.pc",    PCD, 32'h0);
    check("bub.valid", 32'(ValidD), 32'h0);
    check_fields("bub", 5'd0, 5'd0, 5'd0);
    check("bub.cnt",   BubbleCnt, Perf ? 32'd2 : 32'd0);
    check("bub.fcnt",  FlushCnt, Perf ? 32'd1 : 32'd0);

    // Reset asserted mid-stall after loading a real instruction
    fetch(32'h0020_80B3, 32'h300);
    step();
    StallD = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.timeout", 32'(StallTimeout), 32'h0);
    check("arst.instr",   InstrD, 32'h0000_0013);
    check("arst.valid",   32'(ValidD), 32'h0);
    check("arst.scnt",    StallCnt, 32'h0);
    check("arst.bcnt",    BubbleCnt, 32'h0);
    step();

    // Watchdog must restart from zero after reset: 3 stalls do not trip it
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("arst.wd", 32'(StallTimeout), 32'h0);
    step();
    check("arst.wd4", 32'(StallTimeout), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
